sdram_dev_model: RTL and testbench
==================================

Name: sdram_dev_model

Overview:
- Synthesizable single-data-rate SDRAM device responder: the subordinate end of the team's SDRAM device interface (cke/cs/cmd/dqm/addr/ba/write_data/wr_en/read_data).
- Decodes controller commands, tracks per-bank open rows, stores data in a small on-chip array, and returns read data with programmable CAS latency.
- Flags protocol violations with a sticky error and a first-error code.
- Used as the memory stand-in for controller simulation and FPGA loopback builds.

Parameters:
- ROW_WIDTH, 13, row address bits on addr.
- COL_WIDTH, 9, column bits (addr[COL_WIDTH-1:0]).
- ROW_MEM_BITS, 2, low row bits used for storage indexing.
- COL_MEM_BITS, 6, low column bits used for storage indexing.
- DELAY_RCD, 1, minimum edges from ACTIVATE to READ/WRITE on the same bank.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cke  in  1  clock enable; 0 forces command = NOP.
- cs  in  1  chip select, active low; 1 forces command = NOP.
- cmd  in  3  {RAS,CAS,WE}: 011 ACT, 010 PRE, 100 WR, 101 RD, 000 MRS, 111 NOP, 110 BST, 001 REF.
- dqm  in  2  write byte mask; bit=1 suppresses that byte.
- addr  in  ROW_WIDTH  row, column, or mode word; addr[10] = precharge-all on PRE.
- ba  in  2  bank select.
- write_data  in  16  write beat.
- wr_en  in  1  write beat valid.
- read_data  out  16  registered read beat.
- init_done  out  1  init sequence seen.
- err  out  1  sticky protocol error.
- err_code  out  3  code of the first error.

Behaviour:
- Reset (async):
  - read_data=0, init_done=0, err=0, err_code=0.
  - All banks closed; read pipeline and pending write beat cleared.
  - Mode: CL=2, BL=1. Storage array not cleared.
- Storage index: {ba, row[ROW_MEM_BITS-1:0], col[COL_MEM_BITS-1:0]} gives 1024x16 at defaults. Higher bits alias.
- Command sampling: on each rising edge when cke=1 and cs=0.
- Init tracker:
  - Required sequence: PRE with addr[10]=1, then >=2 REF, then MRS.
  - init_done rises on the edge after that MRS.
  - ACT/RD/WR before init_done → error 1, command ignored.
- MRS:
  - CL = addr[6:4]; only 2 or 3 legal.
  - BL = addr[2:0]; only 0 (BL1) and 1 (BL2) legal.
  - Illegal value → error 5, field unchanged.
- ACT: on an open bank → error 2, ignored. Otherwise opens the bank, latches the row, and restarts that bank's tRCD counter.
- PRE: addr[10]=1 closes all banks; else closes bank ba. PRE on an already-closed bank is legal.
- REF: with any bank open → error 4. REF is otherwise a no-op apart from init tracking.
- RD/WR addressing:
  - RD/WR on a closed bank → error 3, ignored.
  - Fewer than DELAY_RCD edges since that bank's ACT → error 6, but the access is still executed.
  - Column is addr[COL_WIDTH-1:0]; row is the bank's latched row.
- Read timing:
  - RD sampled at edge N: beat 0 is loaded into read_data at edge N+CL-1, so it is stable at edge N+CL.
  - BL2 adds beat 1 one edge later at column {col[msb:1], ~col[0]} (sequential wrap within the pair).
  - read_data returns to 0 on the edge after the last beat.
  - Pipeline is a 4-slot shift register of {valid, index}. A newer RD overwrites overlapping slots, so the newer command wins.
- Write timing:
  - WR sampled at edge N with wr_en=1 writes write_data to the index, with bytes gated by dqm.
  - wr_en=0 on WR → no store.
  - BL2 beat 1 at edge N+1 (paired column), stored only if wr_en=1 that edge.
- Interrupts:
  - WR while read beats are pending clears the read pipeline; read_data=0 next edge.
  - BST clears the read pipeline and any pending write beat 1.
- Errors: err is sticky; err_code holds the first error only. Errors never block later legal commands.
- cke=0: in-flight read beats still drain.
- Reset mid-burst: everything is aborted immediately and no partial write occurs after reset.

Test Plan:
- Init: PRE(addr=0x400), REF, REF, MRS(addr=0x020) → init_done=1 next edge, CL=2, BL=1, err=0.
- Write/read: ACT ba=1 row=0x003; WR col=0x05 data=0xBEEF dqm=00; RD col=0x05 at edge N → read_data=0xBEEF stable at N+2, 0 at N+3.
- Byte mask and CL3: MRS 0x030; WR 0x1234 then WR 0xABCD dqm=10 at the same address; RD → 0x12CD, first valid at edge N+3.
- BL2 wrap: MRS 0x021; WR col=0x07 beats 0x1111/0x2222; RD col=0x07 → 0x1111 at N+2, then 0x2222 (col 0x06) at N+3.
- Errors: RD to closed bank 2 → err=1, err_code=3, read_data stays 0. A following ACT on an open bank leaves err_code=3.
- Interrupt/reset: RD at N, BST at N+1 → read_data stays 0. Assert rst during a BL2 write after beat 0 → beat 1 location unchanged, all outputs at reset values.

Source files
------------

// File: rtl/sdram_dev_model_if.sv
// SDRAM device bus: controller side is the master, the device model is the slave.
interface sdram_dev_model_if #(
    parameter int ROW_WIDTH = 13
);
    logic                 cke;
    logic                 cs;
    logic [2:0]           cmd;
    logic [1:0]           dqm;
    logic [ROW_WIDTH-1:0] addr;
    logic [1:0]           ba;
    logic [15:0]          write_data;
    logic                 wr_en;
    logic [15:0]          read_data;
    logic                 init_done;
    logic                 err;
    logic [2:0]           err_code;

    modport master (
        output cke, cs, cmd, dqm, addr, ba, write_data, wr_en,
        input  read_data, init_done, err, err_code
    );

    modport slave (
        input  cke, cs, cmd, dqm, addr, ba, write_data, wr_en,
        output read_data, init_done, err, err_code
    );
endinterface

// File: rtl/sdram_dev_model.sv
// SDR SDRAM device responder: command decode, per-bank open rows, small backing
// store, CAS-latency read pipeline, and sticky first-error reporting.
module sdram_dev_model #(
    parameter int ROW_WIDTH    = 13,
    parameter int COL_WIDTH    = 9,
    parameter int ROW_MEM_BITS = 2,
    parameter int COL_MEM_BITS = 6,
    parameter int DELAY_RCD    = 1
) (
    input  logic              clk,
    input  logic              rst,
    sdram_dev_model_if.slave  bus
);
    localparam int IDX_W = 2 + ROW_MEM_BITS + COL_MEM_BITS;
    localparam int DEPTH = 1 << IDX_W;
    localparam int RCD_W = $clog2(DELAY_RCD + 2);
    localparam logic [RCD_W-1:0] RCD_MAX = RCD_W'(DELAY_RCD);
    localparam logic [RCD_W:0]   RCD_LIM = (RCD_W + 1)'(DELAY_RCD);

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
        CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
    } cmd_e;

    typedef enum logic [2:0] {
        INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS, INIT_LATCH, INIT_DONE
    } init_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } slot_t;

    logic [15:0] mem [DEPTH];

    logic [3:0]              open_q, open_d;
    logic [ROW_MEM_BITS-1:0] row_q [4];
    logic [ROW_MEM_BITS-1:0] row_d [4];
    logic [RCD_W-1:0]        rcd_q [4];
    logic [RCD_W-1:0]        rcd_d [4];
    logic                    cl3_q, cl3_d;
    logic                    bl2_q, bl2_d;
    init_e                   init_q, init_d;
    logic                    init_done_q, init_done_d;
    slot_t                   pipe_q [4];
    slot_t                   pipe_d [4];
    logic                    wpend_q, wpend_d;
    logic [IDX_W-1:0]        widx_q, widx_d;
    logic [15:0]             read_data_q, read_data_d;
    logic                    err_q, err_d;
    logic [2:0]              err_code_q, err_code_d;

    cmd_e             cmd_c;
    logic [IDX_W-1:0] acc_idx, pair_idx;
    logic             rcd_early;
    logic             mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [15:0]      mem_data;
    logic [1:0]       mem_mask;
    logic             err_now;
    logic [2:0]       code_now;

    logic [ROW_WIDTH-1:0] unused_addr;
    logic [COL_WIDTH-1:0] unused_col;
    assign unused_addr = bus.addr;
    assign unused_col  = bus.addr[COL_WIDTH-1:0];

    always_comb begin
        cmd_c = CMD_NOP;
        if (bus.cke && !bus.cs) cmd_c = cmd_e'(bus.cmd);
        acc_idx   = {bus.ba, row_q[bus.ba], bus.addr[COL_MEM_BITS-1:0]};
        pair_idx  = {acc_idx[IDX_W-1:1], ~acc_idx[0]};
        rcd_early = ({1'b0, rcd_q[bus.ba]} + 1'b1) < RCD_LIM;

        open_d      = open_q;
        row_d       = row_q;
        rcd_d       = rcd_q;
        cl3_d       = cl3_q;
        bl2_d       = bl2_q;
        init_d      = init_q;
        init_done_d = init_done_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (rcd_q[i] != RCD_MAX) rcd_d[i] = rcd_q[i] + 1'b1;
        end
        for (int unsigned i = 0; i < 3; i++) pipe_d[i] = pipe_q[i+1];
        pipe_d[3]   = '0;
        read_data_d = pipe_q[0].valid ? mem[pipe_q[0].idx] : '0;
        wpend_d     = 1'b0;
        widx_d      = widx_q;
        // Pending BL2 beat 1 lands this edge unless a WR or BST below overrides it.
        mem_we      = wpend_q && bus.wr_en;
        mem_idx     = widx_q;
        mem_data    = bus.write_data;
        mem_mask    = bus.dqm;
        err_now     = 1'b0;
        code_now    = '0;

        case (init_q)
            INIT_PRE:   if (cmd_c == CMD_PRE && bus.addr[10]) init_d = INIT_REF1;
            INIT_REF1:  if (cmd_c == CMD_REF) init_d = INIT_REF2;
            INIT_REF2:  if (cmd_c == CMD_REF) init_d = INIT_MRS;
            INIT_MRS:   if (cmd_c == CMD_MRS) init_d = INIT_LATCH;
            INIT_LATCH: begin
                init_d      = INIT_DONE;
                init_done_d = 1'b1;
            end
            INIT_DONE:  ;
            default:    init_d = INIT_PRE;
        endcase

        case (cmd_c)
            CMD_ACT: begin
                if (!init_done_q) begin
                    err_now = 1'b1; code_now = 3'd1;
                end else if (open_q[bus.ba]) begin
                    err_now = 1'b1; code_now = 3'd2;
                end else begin
                    open_d[bus.ba] = 1'b1;
                    row_d[bus.ba]  = bus.addr[ROW_MEM_BITS-1:0];
                    rcd_d[bus.ba]  = '0;
                end
            end
            CMD_PRE: begin
                if (bus.addr[10]) open_d = '0;
                else              open_d[bus.ba] = 1'b0;
            end
            CMD_REF: begin
                if (|open_q) begin
                    err_now = 1'b1; code_now = 3'd4;
                end
            end
            CMD_MRS: begin
                if (bus.addr[6:4] == 3'd2)      cl3_d = 1'b0;
                else if (bus.addr[6:4] == 3'd3) cl3_d = 1'b1;
                else begin
                    err_now = 1'b1; code_now = 3'd5;
                end
                if (bus.addr[2:0] == 3'd0)      bl2_d = 1'b0;
                else if (bus.addr[2:0] == 3'd1) bl2_d = 1'b1;
                else begin
                    err_now = 1'b1; code_now = 3'd5;
                end
            end
            CMD_RD, CMD_WR: begin
                if (!init_done_q) begin
                    err_now = 1'b1; code_now = 3'd1;
                end else if (!open_q[bus.ba]) begin
                    err_now = 1'b1; code_now = 3'd3;
                end else begin
                    if (rcd_early) begin
                        err_now = 1'b1; code_now = 3'd6;
                    end
                    if (cmd_c == CMD_RD) begin
                        // Slot k reaches read_data k+1 edges later, so beat 0 goes to slot CL-2.
                        if (cl3_q) begin
                            pipe_d[1] = {1'b1, acc_idx};
                            if (bl2_q) pipe_d[2] = {1'b1, pair_idx};
                        end else begin
                            pipe_d[0] = {1'b1, acc_idx};
                            if (bl2_q) pipe_d[1] = {1'b1, pair_idx};
                        end
                    end else begin
                        pipe_d      = '{default: '0};
                        read_data_d = '0;
                        mem_we      = bus.wr_en;
                        mem_idx     = acc_idx;
                        wpend_d     = bl2_q;
                        widx_d      = pair_idx;
                    end
                end
            end
            CMD_BST: begin
                pipe_d      = '{default: '0};
                read_data_d = '0;
                mem_we      = 1'b0;
            end
            default: ;
        endcase

        err_d      = err_q | err_now;
        err_code_d = (err_now && !err_q) ? code_now : err_code_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_q      <= '0;
            row_q       <= '{default: '0};
            rcd_q       <= '{default: '0};
            cl3_q       <= 1'b0;
            bl2_q       <= 1'b0;
            init_q      <= INIT_PRE;
            init_done_q <= 1'b0;
            pipe_q      <= '{default: '0};
            wpend_q     <= 1'b0;
            widx_q      <= '0;
            read_data_q <= '0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
        end else begin
            open_q      <= open_d;
            row_q       <= row_d;
            rcd_q       <= rcd_d;
            cl3_q       <= cl3_d;
            bl2_q       <= bl2_d;
            init_q      <= init_d;
            init_done_q <= init_done_d;
            pipe_q      <= pipe_d;
            wpend_q     <= wpend_d;
            widx_q      <= widx_d;
            read_data_q <= read_data_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    // No reset: contents survive reset; writes need init_done or a pending beat, both cleared by rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (!mem_mask[0]) mem[mem_idx][7:0]  <= mem_data[7:0];
            if (!mem_mask[1]) mem[mem_idx][15:8] <= mem_data[15:8];
        end
    end

    assign bus.read_data = read_data_q;
    assign bus.init_done = init_done_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_sdram_dev_model.sv
// Directed and randomized bench for sdram_dev_model against a cycle-indexed reference model.
module tb_sdram_dev_model;
    localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
                           C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110, C_NOP = 3'b111;
    localparam int DELAY_RCD = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sdram_dev_model_if #(.ROW_WIDTH(13)) bus_if ();

    sdram_dev_model #(
        .ROW_WIDTH(13), .COL_WIDTH(9), .ROW_MEM_BITS(2), .COL_MEM_BITS(6), .DELAY_RCD(DELAY_RCD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: memory image, bank table, and read beats scheduled by absolute edge number.
    logic [15:0] ref_mem [1024];
    bit          m_open [4];
    int          m_row [4];
    int          m_act_t [4];
    int          m_cl, m_bl;
    bit          m_pre_ok;
    int          m_refs, m_init_at;
    bit          sched_v [8];
    int          sched_i [8];
    bit          pend_v;
    int          pend_i;
    bit          m_err;
    int          m_code;
    int          t = 0;
    logic [15:0] exp_rd;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_open[i] = 0;
        for (int i = 0; i < 8; i++) sched_v[i] = 0;
        m_cl = 2; m_bl = 1; m_pre_ok = 0; m_refs = 0; m_init_at = -1;
        pend_v = 0; m_err = 0; m_code = 0; exp_rd = 16'h0;
    endtask

    task automatic model_err(input int code);
        if (!m_err) begin
            m_err  = 1;
            m_code = code;
        end
    endtask

    task automatic mem_write(input int i, input logic [15:0] d, input logic [1:0] m);
        if (!m[0]) ref_mem[i][7:0]  = d[7:0];
        if (!m[1]) ref_mem[i][15:8] = d[15:8];
    endtask

    task automatic model_edge(input logic [2:0] c_in, input logic [1:0] b, input logic [12:0] a,
                              input logic [15:0] wd, input logic [1:0] m, input logic we,
                              input logic ck, input logic csn);
        logic [2:0] c;
        int bi, idx;
        bit ready, wr_exec;
        c       = (ck && !csn) ? c_in : C_NOP;
        bi      = int'(b);
        ready   = (m_init_at >= 0) && (t > m_init_at);
        idx     = bi * 256 + (m_row[bi] % 4) * 64 + (int'(a) % 64);
        exp_rd  = sched_v[t % 8] ? ref_mem[sched_i[t % 8]] : 16'h0;
        sched_v[t % 8] = 0;
        wr_exec = (c == C_WR) && ready && m_open[bi];
        if (pend_v && c != C_BST && !wr_exec && we) mem_write(pend_i, wd, m);
        pend_v = 0;

        if (!m_pre_ok) begin
            if (c == C_PRE && a[10]) m_pre_ok = 1;
        end else if (m_refs < 2) begin
            if (c == C_REF) m_refs++;
        end else if (m_init_at < 0 && c == C_MRS) begin
            m_init_at = t + 1;
        end

        case (c)
            C_ACT: begin
                if (!ready) model_err(1);
                else if (m_open[bi]) model_err(2);
                else begin
                    m_open[bi] = 1; m_row[bi] = int'(a); m_act_t[bi] = t;
                end
            end
            C_PRE: begin
                if (a[10]) for (int i = 0; i < 4; i++) m_open[i] = 0;
                else m_open[bi] = 0;
            end
            C_REF: if (m_open[0] || m_open[1] || m_open[2] || m_open[3]) model_err(4);
            C_MRS: begin
                if (a[6:4] == 3'd2 || a[6:4] == 3'd3) m_cl = int'(a[6:4]);
                else model_err(5);
                if (a[2:0] == 3'd0) m_bl = 1;
                else if (a[2:0] == 3'd1) m_bl = 2;
                else model_err(5);
            end
            C_RD, C_WR: begin
                if (!ready) model_err(1);
                else if (!m_open[bi]) model_err(3);
                else begin
                    if (t - m_act_t[bi] < DELAY_RCD) model_err(6);
                    if (c == C_RD) begin
                        sched_v[(t + m_cl - 1) % 8] = 1;
                        sched_i[(t + m_cl - 1) % 8] = idx;
                        if (m_bl == 2) begin
                            sched_v[(t + m_cl) % 8] = 1;
                            sched_i[(t + m_cl) % 8] = idx ^ 1;
                        end
                    end else begin
                        for (int i = 0; i < 8; i++) sched_v[i] = 0;
                        exp_rd = 16'h0;
                        if (we) mem_write(idx, wd, m);
                        if (m_bl == 2) begin
                            pend_v = 1;
                            pend_i = idx ^ 1;
                        end
                    end
                end
            end
            C_BST: begin
                for (int i = 0; i < 8; i++) sched_v[i] = 0;
                exp_rd = 16'h0;
            end
            default: ;
        endcase
    endtask

    task automatic cyc(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [15:0] wd, input logic [1:0] m, input logic we,
                       input logic ck, input logic csn);
        @(negedge clk);
        bus_if.cke = ck; bus_if.cs = csn; bus_if.cmd = c; bus_if.ba = b; bus_if.addr = a;
        bus_if.write_data = wd; bus_if.dqm = m; bus_if.wr_en = we;
        @(posedge clk);
        t++;
        model_edge(c, b, a, wd, m, we, ck, csn);
        #1;
        check($sformatf("read_data@%0d", t), bus_if.read_data, exp_rd);
        check($sformatf("err@%0d", t), bus_if.err, m_err);
        check($sformatf("err_code@%0d", t), bus_if.err_code, m_code);
        check($sformatf("init_done@%0d", t), bus_if.init_done,
              (m_init_at >= 0 && t >= m_init_at) ? 1 : 0);
    endtask

    task automatic op(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
        cyc(c, b, a, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic init_seq(input logic [12:0] mode);
        op(C_PRE, 2'd0, 13'h400);
        op(C_REF, 2'd0, 13'h0);
        op(C_REF, 2'd0, 13'h0);
        op(C_MRS, 2'd0, mode);
        check("init_done_at_mrs", bus_if.init_done, 0);
        op(C_NOP, 2'd0, 13'h0);
        check("init_done_next", bus_if.init_done, 1);
        check("init_err", bus_if.err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] saved;
        int          r;
        logic [2:0]  rc;
        logic [12:0] ra;
        bus_if.cke = 1'b1; bus_if.cs = 1'b1; bus_if.cmd = C_NOP; bus_if.dqm = 2'b00;
        bus_if.addr = '0; bus_if.ba = '0; bus_if.write_data = '0; bus_if.wr_en = 1'b0;
        model_reset();
        #1;
        check("rst_read_data", bus_if.read_data, 16'h0);
        check("rst_init_done", bus_if.init_done, 0);
        check("rst_err", bus_if.err, 0);
        check("rst_err_code", bus_if.err_code, 0);
        @(negedge clk);
        rst = 1'b0;

        init_seq(13'h020);

        for (int b = 0; b < 4; b++) begin
            for (int rw = 0; rw < 4; rw++) begin
                op(C_ACT, 2'(b), 13'(rw));
                for (int c = 0; c < 64; c++)
                    cyc(C_WR, 2'(b), 13'(c), 16'($urandom()), 2'b00, 1'b1, 1'b1, 1'b0);
                op(C_PRE, 2'(b), 13'h0);
            end
        end

        op(C_ACT, 2'd1, 13'h003);
        cyc(C_WR, 2'd1, 13'h005, 16'hBEEF, 2'b00, 1'b1, 1'b1, 1'b0);
        op(C_RD, 2'd1, 13'h005);
        op(C_NOP, 2'd0, 13'h0);
        check("wr_rd_beef", bus_if.read_data, 16'hBEEF);
        op(C_NOP, 2'd0, 13'h0);
        check("wr_rd_idle", bus_if.read_data, 16'h0);

        op(C_MRS, 2'd0, 13'h030);
        cyc(C_WR, 2'd1, 13'h00A, 16'h1234, 2'b00, 1'b1, 1'b1, 1'b0);
        cyc(C_WR, 2'd1, 13'h00A, 16'hABCD, 2'b10, 1'b1, 1'b1, 1'b0);
        op(C_RD, 2'd1, 13'h00A);
        op(C_NOP, 2'd0, 13'h0);
        check("cl3_not_early", bus_if.read_data, 16'h0);
        op(C_NOP, 2'd0, 13'h0);
        check("cl3_dqm_merge", bus_if.read_data, 16'h12CD);

        op(C_MRS, 2'd0, 13'h021);
        cyc(C_WR, 2'd1, 13'h007, 16'h1111, 2'b00, 1'b1, 1'b1, 1'b0);
        cyc(C_NOP, 2'd0, 13'h0, 16'h2222, 2'b00, 1'b1, 1'b1, 1'b0);
        op(C_RD, 2'd1, 13'h007);
        op(C_NOP, 2'd0, 13'h0);
        check("bl2_beat0", bus_if.read_data, 16'h1111);
        op(C_NOP, 2'd0, 13'h0);
        check("bl2_beat1_wrap", bus_if.read_data, 16'h2222);
        op(C_NOP, 2'd0, 13'h0);
        check("bl2_idle", bus_if.read_data, 16'h0);

        op(C_MRS, 2'd0, 13'h020);
        op(C_RD, 2'd1, 13'h005);
        op(C_BST, 2'd0, 13'h0);
        check("bst_kill", bus_if.read_data, 16'h0);
        op(C_NOP, 2'd0, 13'h0);
        check("bst_idle", bus_if.read_data, 16'h0);

        op(C_RD, 2'd2, 13'h005);
        check("closed_err", bus_if.err, 1);
        check("closed_code", bus_if.err_code, 3);
        op(C_NOP, 2'd0, 13'h0);
        check("closed_no_data", bus_if.read_data, 16'h0);
        op(C_ACT, 2'd1, 13'h001);
        check("first_code_kept", bus_if.err_code, 3);

        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(0, 99);
            ra = 13'($urandom());
            ra[10] = ($urandom_range(0, 4) == 0);
            if (r < 15)      rc = C_ACT;
            else if (r < 25) rc = C_PRE;
            else if (r < 50) rc = C_RD;
            else if (r < 75) rc = C_WR;
            else if (r < 80) rc = C_BST;
            else if (r < 84) begin
                rc = C_MRS;
                ra = 13'(($urandom_range(2, 3) << 4) | $urandom_range(0, 1));
            end
            else if (r < 86) rc = C_REF;
            else             rc = C_NOP;
            cyc(rc, 2'($urandom()), ra, 16'($urandom()), 2'($urandom()),
                $urandom_range(0, 4) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0);
        end

        op(C_BST, 2'd0, 13'h0);
        op(C_PRE, 2'd0, 13'h400);
        op(C_MRS, 2'd0, 13'h021);
        op(C_ACT, 2'd3, 13'h002);
        saved = ref_mem[3 * 256 + 2 * 64 + 17];
        cyc(C_WR, 2'd3, 13'h010, 16'h5555, 2'b00, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        bus_if.cmd = C_NOP; bus_if.wr_en = 1'b1; bus_if.write_data = 16'hDEAD; bus_if.dqm = 2'b00;
        #1 rst = 1'b1;
        #1;
        model_reset();
        check("midrst_read_data", bus_if.read_data, 16'h0);
        check("midrst_init_done", bus_if.init_done, 0);
        check("midrst_err", bus_if.err, 0);
        check("midrst_err_code", bus_if.err_code, 0);
        @(posedge clk);
        t++;
        @(negedge clk);
        rst = 1'b0;
        bus_if.wr_en = 1'b0;
        bus_if.cs = 1'b1;
        @(posedge clk);
        t++;
        model_edge(C_NOP, 2'd0, 13'h0, 16'h0, 2'b00, 1'b0, 1'b1, 1'b1);

        init_seq(13'h020);
        op(C_ACT, 2'd3, 13'h002);
        op(C_RD, 2'd3, 13'h011);
        op(C_NOP, 2'd0, 13'h0);
        check("rst_beat1_kept", bus_if.read_data, saved);
        op(C_RD, 2'd3, 13'h010);
        op(C_NOP, 2'd0, 13'h0);
        check("rst_beat0_done", bus_if.read_data, 16'h5555);
        op(C_NOP, 2'd0, 13'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
